// File: rtl/contador_tiempo_pkg.sv
// reloj_pkg: constants and the time record shared by the timekeeping core,
// the display block and the minute/hour adjust blocks.
//   SEG_MAX / MIN_MAX : last value before wrap for seconds and minutes
//   SEG_W / MIN_W / HR_W : field widths of seconds, minutes and hours
//   tiempo_t : packed {hr, min, seg} time record
package reloj_pkg;

   localparam int SEG_MAX = 59;
   localparam int MIN_MAX = 59;
   localparam int SEG_W   = 6;
   localparam int MIN_W   = 6;
   localparam int HR_W    = 5;

   typedef struct packed {
      logic [HR_W-1:0]  hr;
      logic [MIN_W-1:0] min;
      logic [SEG_W-1:0] seg;
   } tiempo_t;

endpackage

// File: rtl/contador_tiempo_if.sv
// contador_tiempo_if: mode/adjust inputs and time outputs of the timekeeping core.
//   master : the adjust/control side (drives switch, minChange, hrInc, alarm setup)
//   slave  : contador_tiempo (drives seg, min, hr, secTick, alarma)
// Optional feature macro: ALARM_EN adds alarmMin, alarmHr, alarmOn, alarmOff.
interface contador_tiempo_if;
   import reloj_pkg::*;

   logic             switch;
   logic [MIN_W-1:0] minChange;
   logic             hrInc;
   logic [SEG_W-1:0] seg;
   logic [MIN_W-1:0] min;
   logic [HR_W-1:0]  hr;
   logic             secTick;
   logic             alarma;

`ifdef ALARM_EN
   logic [MIN_W-1:0] alarmMin;
   logic [HR_W-1:0]  alarmHr;
   logic             alarmOn;
   logic             alarmOff;

   modport master (output switch, minChange, hrInc, alarmMin, alarmHr, alarmOn, alarmOff,
                   input  seg, min, hr, secTick, alarma);
   modport slave  (input  switch, minChange, hrInc, alarmMin, alarmHr, alarmOn, alarmOff,
                   output seg, min, hr, secTick, alarma);
`else
   modport master (output switch, minChange, hrInc,
                   input  seg, min, hr, secTick, alarma);
   modport slave  (input  switch, minChange, hrInc,
                   output seg, min, hr, secTick, alarma);
`endif

endinterface

// File: rtl/contador_tiempo_mod.sv
// contador_mod: wrapping up-counter 0..MAX with carry chaining.
//   clkS, rst_n : clock, async active-low reset (q -> 0)
//   en          : carry-in, advance by one this cycle
//   load/loadVal: synchronous load, has priority over en
//   q           : current count
//   carryOut    : en while q==MAX, i.e. this counter wraps on this edge
module contador_mod #(
   parameter int MAX = 59,
   parameter int W   = 6
) (
   input  logic         clkS,
   input  logic         rst_n,
   input  logic         en,
   input  logic         load,
   input  logic [W-1:0] loadVal,
   output logic [W-1:0] q,
   output logic         carryOut
);

   localparam logic [W-1:0] MAX_V = W'(MAX);

   // Combinational so a full chain of carries resolves in a single edge.
   assign carryOut = en && (q == MAX_V);

   always_ff @(posedge clkS or negedge rst_n) begin
      if (!rst_n) begin
         q <= '0;
      end else if (load) begin
         q <= loadVal;
      end else if (en) begin
         q <= carryOut ? '0 : q + W'(1);
      end
   end

endmodule

// File: rtl/contador_tiempo.sv
// contador_tiempo: HH:MM:SS timekeeping core.
//   clkS   : system clock
//   rst_n  : async active-low reset
//   bus    : contador_tiempo_if.slave
//            in : switch (1=set, 0=run), minChange, hrInc
//            out: seg, min, hr, secTick, alarma
// Parameters: CLK_HZ (clock cycles per second), HR_MAX (last hour before wrap).
// Optional feature macro: ALARM_EN enables the hr:min alarm; otherwise alarma is tied 0.
module contador_tiempo
   import reloj_pkg::*;
#(
   parameter int CLK_HZ = 100_000_000,
   parameter int HR_MAX = 23
) (
   input logic               clkS,
   input logic               rst_n,
   contador_tiempo_if.slave  bus
);

   localparam int             PW     = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PW-1:0]  PRE_TC = PW'(CLK_HZ - 1);

   logic [PW-1:0]    prescaler;
   logic             swD;
   logic             secTickQ;
   logic             tick;
   logic             segCarry;
   logic             minCarry;
   logic             hrCarry;
   logic             minLoad;
   logic             hrEn;
   logic [SEG_W-1:0] segQ;
   logic [MIN_W-1:0] minQ;
   logic [HR_W-1:0]  hrQ;

   // A second elapses only in run mode; set mode freezes the prescaler at 0.
   assign tick = !bus.switch && (prescaler == PRE_TC);

   // minChange lags switch by one cycle upstream, so only load once switch was
   // already high on the previous cycle.
   assign minLoad = swD && bus.switch && (bus.minChange <= MIN_W'(MIN_MAX));

   // minCarry is only ever set in run mode, hrInc only counts in set mode.
   assign hrEn = (bus.switch && bus.hrInc) || minCarry;

   always_ff @(posedge clkS or negedge rst_n) begin
      if (!rst_n) begin
         prescaler <= '0;
         swD       <= 1'b0;
         secTickQ  <= 1'b0;
      end else begin
         swD      <= bus.switch;
         secTickQ <= tick;
         if (bus.switch || tick) begin
            prescaler <= '0;
         end else begin
            prescaler <= prescaler + PW'(1);
         end
      end
   end

   contador_mod #(.MAX(SEG_MAX), .W(SEG_W)) u_seg (
      .clkS     (clkS),
      .rst_n    (rst_n),
      .en       (tick),
      .load     (bus.switch),
      .loadVal  ('0),
      .q        (segQ),
      .carryOut (segCarry)
   );

   contador_mod #(.MAX(MIN_MAX), .W(MIN_W)) u_min (
      .clkS     (clkS),
      .rst_n    (rst_n),
      .en       (segCarry),
      .load     (minLoad),
      .loadVal  (bus.minChange),
      .q        (minQ),
      .carryOut (minCarry)
   );

   contador_mod #(.MAX(HR_MAX), .W(HR_W)) u_hr (
      .clkS     (clkS),
      .rst_n    (rst_n),
      .en       (hrEn),
      .load     (1'b0),
      .loadVal  ('0),
      .q        (hrQ),
      .carryOut (hrCarry)
   );

   assign bus.seg     = segQ;
   assign bus.min     = minQ;
   assign bus.hr      = hrQ;
   assign bus.secTick = secTickQ;

`ifdef ALARM_EN
   logic             alarmQ;
   logic [MIN_W-1:0] newMin;
   logic [HR_W-1:0]  newHr;
   logic             alarmHit;

   // hr:min as it will be after this edge's minute rollover.
   assign newMin   = minCarry ? '0 : minQ + MIN_W'(1);
   assign newHr    = minCarry ? (hrCarry ? '0 : hrQ + HR_W'(1)) : hrQ;
   assign alarmHit = (newMin == bus.alarmMin) && (newHr == bus.alarmHr);

   // Each minute rollover re-evaluates the match, so a raised alarm drops
   // 60 s later on its own.
   always_ff @(posedge clkS or negedge rst_n) begin
      if (!rst_n) begin
         alarmQ <= 1'b0;
      end else if (bus.switch || !bus.alarmOn || bus.alarmOff) begin
         alarmQ <= 1'b0;
      end else if (segCarry) begin
         alarmQ <= alarmHit;
      end
   end

   assign bus.alarma = alarmQ;
`else
   logic unusedHrCarry;
   assign unusedHrCarry = hrCarry;
   assign bus.alarma    = 1'b0;
`endif

endmodule

// File: tb/tb_contador_tiempo.sv
// tb_contador_tiempo: self-checking bench for contador_tiempo (CLK_HZ=4).
// Reference model keeps the time as seconds-of-day plus a sub-second phase.
// Optional feature macro: ALARM_EN enables the alarm sequences.
module tb_contador_tiempo;

   localparam int CLK_HZ = 4;
   localparam int HR_MAX = 23;
   localparam int DAY    = (HR_MAX + 1) * 3600;

   logic clkS = 1'b0;
   logic rst_n = 1'b0;

   contador_tiempo_if bus ();

   contador_tiempo #(.CLK_HZ(CLK_HZ), .HR_MAX(HR_MAX)) dut (
      .clkS  (clkS),
      .rst_n (rst_n),
      .bus   (bus.slave)
   );

   always #5 clkS = ~clkS;

   int   checks = 0;
   int   errors = 0;

   int   mT;
   int   mPhase;
   logic mSwPrev;
   logic mTick;
   logic mAlarm;
   logic rsw;

   int   aMin = 0;
   int   aHr  = 0;
   logic aOn  = 1'b0;
   logic aOff = 1'b0;

   typedef struct packed {
      logic       sw;
      logic [5:0] mc;
      logic       hi;
      logic [5:0] eSeg;
      logic [5:0] eMin;
      logic [4:0] eHr;
      logic       eTick;
   } vec_t;

   vec_t tbl [12];

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic driveAlarm();
`ifdef ALARM_EN
      bus.alarmMin = 6'(aMin);
      bus.alarmHr  = 5'(aHr);
      bus.alarmOn  = aOn;
      bus.alarmOff = aOff;
`endif
   endtask

   // Called away from the clock edge; applies one cycle of inputs, advances the
   // model by one edge and compares all outputs just after that edge.
   task automatic cyc(input logic sw, input int mc, input logic hi);
      int   h;
      int   m;
      int   nT;
      logic nTick;
      bus.switch    = sw;
      bus.minChange = 6'(mc);
      bus.hrInc     = hi;
      driveAlarm();
      h     = mT / 3600;
      m     = (mT / 60) % 60;
      nT    = mT;
      nTick = 1'b0;
      if (sw) begin
         mPhase = 0;
         if (mSwPrev && mc <= 59) m = mc;
         if (hi) h = (h + 1) % (HR_MAX + 1);
         nT = h * 3600 + m * 60;
      end else if (mPhase == CLK_HZ - 1) begin
         mPhase = 0;
         nT     = (mT + 1) % DAY;
         nTick  = 1'b1;
      end else begin
         mPhase++;
      end
`ifdef ALARM_EN
      if (sw || !aOn || aOff) mAlarm = 1'b0;
      else if (nTick && (nT % 60 == 0)) mAlarm = ((nT / 60) == aHr * 60 + aMin);
`endif
      mSwPrev = sw;
      mT      = nT;
      mTick   = nTick;
      @(posedge clkS);
      #1;
      chk("seg", int'(bus.seg), mT % 60);
      chk("min", int'(bus.min), (mT / 60) % 60);
      chk("hr", int'(bus.hr), mT / 3600);
      chk("secTick", int'(bus.secTick), int'(mTick));
      chk("alarma", int'(bus.alarma), int'(mAlarm));
   endtask

   // Asserts reset delayNs into the call, checks outputs cleared before any
   // clock edge, then releases just after the next rising edge.
   task automatic doReset(input int delayNs);
      #(delayNs);
      rst_n = 1'b0;
      #1;
      chk("rst_seg", int'(bus.seg), 0);
      chk("rst_min", int'(bus.min), 0);
      chk("rst_hr", int'(bus.hr), 0);
      chk("rst_secTick", int'(bus.secTick), 0);
      chk("rst_alarma", int'(bus.alarma), 0);
      bus.switch    = 1'b0;
      bus.minChange = '0;
      bus.hrInc     = 1'b0;
      aOff          = 1'b0;
      driveAlarm();
      @(posedge clkS);
      #1;
      rst_n   = 1'b1;
      mT      = 0;
      mPhase  = 0;
      mSwPrev = 1'b0;
      mTick   = 1'b0;
      mAlarm  = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: time limit reached, got no end, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      //           sw    mc      hi    seg    min     hr     tick
      tbl[0]  = '{1'b1, 6'd37, 1'b0, 6'd0, 6'd0,  5'd0, 1'b0};
      tbl[1]  = '{1'b1, 6'd37, 1'b0, 6'd0, 6'd37, 5'd0, 1'b0};
      tbl[2]  = '{1'b1, 6'd61, 1'b0, 6'd0, 6'd37, 5'd0, 1'b0};
      tbl[3]  = '{1'b1, 6'd60, 1'b0, 6'd0, 6'd37, 5'd0, 1'b0};
      tbl[4]  = '{1'b1, 6'd59, 1'b1, 6'd0, 6'd59, 5'd1, 1'b0};
      tbl[5]  = '{1'b0, 6'd0,  1'b1, 6'd0, 6'd59, 5'd1, 1'b0};
      tbl[6]  = '{1'b0, 6'd0,  1'b0, 6'd0, 6'd59, 5'd1, 1'b0};
      tbl[7]  = '{1'b0, 6'd0,  1'b0, 6'd0, 6'd59, 5'd1, 1'b0};
      tbl[8]  = '{1'b0, 6'd0,  1'b0, 6'd1, 6'd59, 5'd1, 1'b1};
      tbl[9]  = '{1'b0, 6'd5,  1'b0, 6'd1, 6'd59, 5'd1, 1'b0};
      tbl[10] = '{1'b1, 6'd5,  1'b0, 6'd0, 6'd59, 5'd1, 1'b0};
      tbl[11] = '{1'b1, 6'd5,  1'b0, 6'd0, 6'd5,  5'd1, 1'b0};

      bus.switch    = 1'b0;
      bus.minChange = '0;
      bus.hrInc     = 1'b0;
      driveAlarm();
      doReset(1);

      // Set-mode loading, run-mode entry latency and mid-second exit.
      for (int i = 0; i < 12; i++) begin
         cyc(tbl[i].sw, int'(tbl[i].mc), tbl[i].hi);
         chk($sformatf("tbl%0d_seg", i), int'(bus.seg), int'(tbl[i].eSeg));
         chk($sformatf("tbl%0d_min", i), int'(bus.min), int'(tbl[i].eMin));
         chk($sformatf("tbl%0d_hr", i), int'(bus.hr), int'(tbl[i].eHr));
         chk($sformatf("tbl%0d_tick", i), int'(bus.secTick), int'(tbl[i].eTick));
      end

      // Run 8 cycles from reset.
      doReset(3);
      for (int i = 0; i < 8; i++) begin
         cyc(1'b0, 0, 1'b0);
         chk($sformatf("run8_tick_c%0d", i + 1), int'(bus.secTick), (i == 3 || i == 7) ? 1 : 0);
      end
      chk("run8_seg", int'(bus.seg), 2);

      // Async reset mid-count, then preload 23:59 and roll the day over.
      cyc(1'b0, 0, 1'b0);
      doReset(3);
      cyc(1'b1, 59, 1'b0);
      cyc(1'b1, 59, 1'b0);
      for (int i = 0; i < 23; i++) cyc(1'b1, 59, 1'b1);
      chk("set_hr23", int'(bus.hr), 23);
      cyc(1'b1, 59, 1'b1);
      chk("hr_wrap", int'(bus.hr), 0);
      for (int i = 0; i < 23; i++) cyc(1'b1, 59, 1'b1);
      for (int i = 0; i < 59 * CLK_HZ; i++) cyc(1'b0, 0, 1'b0);
      chk("pre_roll_seg", int'(bus.seg), 59);
      chk("pre_roll_min", int'(bus.min), 59);
      chk("pre_roll_hr", int'(bus.hr), 23);
      for (int i = 0; i < CLK_HZ; i++) cyc(1'b0, 0, 1'b0);
      chk("roll_seg", int'(bus.seg), 0);
      chk("roll_min", int'(bus.min), 0);
      chk("roll_hr", int'(bus.hr), 0);
      chk("roll_tick", int'(bus.secTick), 1);

      // Randomized mode switching and adjust traffic.
      rsw = 1'b1;
      for (int i = 0; i < 400; i++) begin
         if ($urandom_range(0, 15) == 0) rsw = ~rsw;
         cyc(rsw, int'($urandom_range(0, 63)), ($urandom_range(0, 3) == 0));
      end

`ifdef ALARM_EN
      aOn = 1'b1;
      aMin = 1;
      aHr = 0;
      doReset(3);
      for (int i = 0; i < 59 * CLK_HZ; i++) cyc(1'b0, 0, 1'b0);
      chk("alarm_before", int'(bus.alarma), 0);
      for (int i = 0; i < CLK_HZ; i++) cyc(1'b0, 0, 1'b0);
      chk("alarm_set", int'(bus.alarma), 1);
      aOff = 1'b1;
      cyc(1'b0, 0, 1'b0);
      aOff = 1'b0;
      chk("alarm_off", int'(bus.alarma), 0);

      doReset(3);
      for (int i = 0; i < 60 * CLK_HZ; i++) cyc(1'b0, 0, 1'b0);
      chk("alarm_set2", int'(bus.alarma), 1);
      for (int i = 0; i < 59 * CLK_HZ; i++) cyc(1'b0, 0, 1'b0);
      chk("alarm_hold", int'(bus.alarma), 1);
      for (int i = 0; i < CLK_HZ; i++) cyc(1'b0, 0, 1'b0);
      chk("alarm_timeout", int'(bus.alarma), 0);
      aOn = 1'b0;
      cyc(1'b0, 0, 1'b0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
